// File: rtl/bf16_pkg.sv
// Shared BF16 field widths, constants and pipeline bundles.
// Imported by the adder and multiplier pipelines.
package bf16_pkg;

   localparam int W      = 16;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 7;
   localparam int SIG_W  = FRAC_W + 1;
   localparam int EXT_W  = SIG_W + 3;
   localparam int SUM_W  = EXT_W + 1;
   localparam int LZC_W  = 4;

   localparam logic [EXP_W-1:0] BIAS    = 8'd127;
   localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
   localparam logic [W-1:0]     QNAN    = 16'hFFC0;
   localparam logic [W-1:0]     POS_INF = 16'h7F80;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } bf16_t;

   typedef struct packed {
      logic             sign_l;
      logic [EXP_W-1:0] exp_l;
      logic [SIG_W-1:0] sig_l;
      logic             sign_s;
      logic [EXP_W-1:0] exp_s;
      logic [SIG_W-1:0] sig_s;
      logic             special;
      logic [W-1:0]     spec_res;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SUM_W-1:0] sum;
      logic             special;
      logic [W-1:0]     spec_res;
   } s2_t;

endpackage

// File: rtl/add_3_stage_pipe_bf16_if.sv
// Operand/result handshake bundle for the BF16 adder pipeline.
// Same result protocol as the multiplier so the two chain directly.
interface add_3_stage_pipe_bf16_if;
   logic [31:0] input_add;
   logic        input_add_stb;
   logic        s_input_add_ack;
   logic [15:0] z;
   logic        s_output_z_stb;

   modport master (
      output input_add, input_add_stb,
      input  s_input_add_ack, z, s_output_z_stb
   );

   modport slave (
      input  input_add, input_add_stb,
      output s_input_add_ack, z, s_output_z_stb
   );
endinterface

// File: rtl/bf16_lzc.sv
// Leading-zero count over the 12-bit aligned sum; all-zero gives 12.
module bf16_lzc
   import bf16_pkg::*;
(
   input  logic [SUM_W-1:0] x,
   output logic [LZC_W-1:0] cnt
);
   always_comb begin
      cnt = LZC_W'(SUM_W);
      for (int i = 0; i < SUM_W; i++) begin
         if (x[i]) cnt = LZC_W'(SUM_W - 1 - i);
      end
   end
endmodule

// File: rtl/add_3_stage_pipe_bf16.sv
// BF16 adder: input capture, then unpack/swap, align/add, normalize/round.
// Round-to-nearest-even, subnormals flushed to zero on input and output.
module add_3_stage_pipe_bf16
   import bf16_pkg::*;
(
   input logic                     clk,
   input logic                     rst,
   add_3_stage_pipe_bf16_if.slave bus
);
   logic [31:0] in_q;
   logic        in_vld;
   logic        ack_q;
   logic [2:0]  vld;
   s1_t         s1_d, s1_q;
   s2_t         s2_d, s2_q;
   logic [W-1:0] z_d, z_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q   <= '0;
         in_vld <= 1'b0;
         ack_q  <= 1'b0;
         vld    <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         z_q    <= '0;
      end else begin
         in_q   <= bus.input_add;
         in_vld <= bus.input_add_stb;
         ack_q  <= 1'b1;
         vld    <= {vld[1:0], in_vld};
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         z_q    <= z_d;
      end
   end

   bf16_t a, b, l, s;
   logic  a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, swap;

   always_comb begin
      a      = in_q[31:16];
      b      = in_q[15:0];
      a_zero = (a.exp == '0);
      b_zero = (b.exp == '0);
      a_nan  = (a.exp == EXP_MAX) && (a.frac != '0);
      b_nan  = (b.exp == EXP_MAX) && (b.frac != '0);
      a_inf  = (a.exp == EXP_MAX) && (a.frac == '0);
      b_inf  = (b.exp == EXP_MAX) && (b.frac == '0);
      // Subnormal fractions are ignored so they never win the swap.
      swap = (b_zero ? 15'd0 : {b.exp, b.frac}) >
             (a_zero ? 15'd0 : {a.exp, a.frac});
      l = swap ? b : a;
      s = swap ? a : b;
      s1_d          = '0;
      s1_d.sign_l   = l.sign;
      s1_d.exp_l    = l.exp;
      s1_d.sig_l    = {1'b1, l.frac};
      s1_d.sign_s   = s.sign;
      s1_d.exp_s    = s.exp;
      s1_d.sig_s    = {1'b1, s.frac};
      s1_d.special  = 1'b1;
      if (a_nan || b_nan)      s1_d.spec_res = QNAN;
      else if (a_inf && b_inf) s1_d.spec_res = (a.sign == b.sign) ? a : QNAN;
      else if (a_inf)          s1_d.spec_res = a;
      else if (b_inf)          s1_d.spec_res = b;
      else if (a_zero && b_zero)
         s1_d.spec_res = {a.sign & b.sign, 15'd0};
      else if (a_zero)         s1_d.spec_res = b;
      else if (b_zero)         s1_d.spec_res = a;
      else                     s1_d.special  = 1'b0;
   end

   logic [EXP_W-1:0] d;
   logic [EXT_W-1:0] la, sa_full, sa;

   always_comb begin
      d       = s1_q.exp_l - s1_q.exp_s;
      la      = {s1_q.sig_l, 3'b000};
      sa_full = {s1_q.sig_s, 3'b000};
      if (d >= EXP_W'(EXT_W)) begin
         sa = EXT_W'(1);
      end else begin
         sa    = sa_full >> d;
         sa[0] = sa[0] | (|(sa_full & ~(11'h7FF << d)));
      end
      s2_d          = '0;
      s2_d.sign     = s1_q.sign_l;
      s2_d.exp      = s1_q.exp_l;
      s2_d.special  = s1_q.special;
      s2_d.spec_res = s1_q.spec_res;
      if (s1_q.sign_l == s1_q.sign_s) s2_d.sum = {1'b0, la} + {1'b0, sa};
      else                            s2_d.sum = {1'b0, la} - {1'b0, sa};
   end

   logic [LZC_W-1:0]  lz;
   logic [SUM_W-1:0]  norm;
   logic signed [9:0] e, e_f;
   logic              inc;
   logic [SIG_W:0]    rnd;

   bf16_lzc u_lzc (.x(s2_q.sum), .cnt(lz));

   always_comb begin
      // Leading one lands on bit 11; a carry needs no shift, hence exp+1-lz.
      norm = s2_q.sum << lz;
      e    = $signed({2'b00, s2_q.exp}) + 10'sd1 - $signed({6'd0, lz});
      inc  = norm[3] & (norm[2] | norm[1] | norm[0] | norm[4]);
      rnd  = {1'b0, norm[11:4]} + {{SIG_W{1'b0}}, inc};
      e_f  = rnd[SIG_W] ? e + 10'sd1 : e;
      z_d  = {s2_q.sign, e_f[7:0], rnd[6:0]};
      if (s2_q.special)          z_d = s2_q.spec_res;
      else if (s2_q.sum == '0)   z_d = '0;
      else if (e_f >= 10'sd255)  z_d = {s2_q.sign, POS_INF[14:0]};
      else if (e_f <= 10'sd0)    z_d = {s2_q.sign, 15'd0};
   end

   assign bus.z               = z_q;
   assign bus.s_output_z_stb  = vld[2];
   assign bus.s_input_add_ack = ack_q;

endmodule
